// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the MEM-stage coprocessor 0: register
//               numbers, ExcCode values, SR/Cause field positions and an
//               address-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] c_reg_count   = 5'd9;
    localparam logic [4:0] c_reg_compare = 5'd11;
    localparam logic [4:0] c_reg_sr      = 5'd12;
    localparam logic [4:0] c_reg_cause   = 5'd13;
    localparam logic [4:0] c_reg_epc     = 5'd14;
    localparam logic [4:0] c_reg_prid    = 5'd15;

    // ExcCode values
    localparam logic [4:0] c_exc_int     = 5'd0;
    localparam logic [4:0] c_exc_adel    = 5'd4;
    localparam logic [4:0] c_exc_ades    = 5'd5;
    localparam logic [4:0] c_exc_syscall = 5'd8;
    localparam logic [4:0] c_exc_ri      = 5'd10;
    localparam logic [4:0] c_exc_ov      = 5'd12;

    // SR / Cause bit-field positions
    localparam int c_sr_ie       = 0;
    localparam int c_sr_exl      = 1;
    localparam int c_im_lo       = 10;
    localparam int c_im_hi       = 15;
    localparam int c_cause_bd    = 31;
    localparam int c_exc_lo      = 2;
    localparam int c_exc_hi      = 6;

    // Word-align an address by forcing the two low bits to zero
    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_if
// Description : M-stage pipeline <-> CP0 signal bundle. The master is the
//               pipeline (issues mtc0/mfc0/eret and exception info); the
//               slave is cp0_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
    logic        req;

    modport master (
        output we, addr, din, pc_in, bd_in, exc_code_in, hw_int, eret,
        input  dout, epc_out, handler_pc, req
    );

    modport slave (
        input  we, addr, din, pc_in, bd_in, exc_code_in, hw_int, eret,
        output dout, epc_out, handler_pc, req
    );
endinterface
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer for CP0. Count free-runs and can be
//               loaded by mtc0; tip is raised when Count is about to reach a
//               non-zero Compare and is cleared by any write to Compare.
//               Only instantiated when CP0_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_count_we,
    input  wire logic        i_compare_we,
    input  wire logic [31:0] i_din,
    output logic [31:0]      o_count,
    output logic [31:0]      o_compare,
    output logic             o_tip
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tip;
    logic [31:0] w_count_inc;

    assign w_count_inc = r_count + 32'd1;

    // Count/Compare registers and the sticky timer-interrupt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_tip     <= 1'b0;
        end else begin
            r_count <= i_count_we ? i_din : w_count_inc;
            if (i_compare_we) begin
                r_compare <= i_din;
                r_tip     <= 1'b0;
            end else if ((w_count_inc == r_compare) && (r_compare != 32'd0)) begin
                r_tip <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_tip     = r_tip;
endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : MEM-stage coprocessor 0. Holds SR/Cause/EPC/PRId, decides
//               interrupt/exception entry (req), and supplies the handler
//               PC and the (bypassed) EPC for eret.
//               Optional macro CP0_TIMER_EN adds Count(9)/Compare(11).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL     = 32'h0000_4180,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  wire logic clk,
    input  wire logic reset,
    cp0_if.slave      bus
);
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_tip;
    logic [5:0]  w_ip_next;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_mtc0;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_mtc0 && (bus.addr == c_reg_count)),
        .i_compare_we (w_mtc0 && (bus.addr == c_reg_compare)),
        .i_din        (bus.din),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_tip        (w_tip)
    );
`else
    assign w_tip = 1'b0;
`endif

    // IP[7] merges the timer flag with the highest external line
    assign w_ip_next = {bus.hw_int[5] | w_tip, bus.hw_int[4:0]};

    // Entry decision uses live interrupt lines so req is seen the same cycle;
    // interrupts win over exceptions, and reset forces req low immediately
    assign w_int_req = (|(w_ip_next & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.exc_code_in != c_exc_int) & ~r_exl;
    assign w_req     = (w_int_req | w_exc_req) & ~reset;
    assign w_mtc0    = bus.we & ~w_req;

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};

    // CP0 state: exception entry has priority over mtc0 and eret
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= w_ip_next;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bus.bd_in;
                r_exc_code <= w_int_req ? c_exc_int : bus.exc_code_in;
                r_epc      <= align4(bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in);
            end else begin
                if (w_mtc0 && (bus.addr == c_reg_sr)) begin
                    r_im  <= bus.din[c_im_hi:c_im_lo];
                    r_exl <= bus.din[c_sr_exl];
                    r_ie  <= bus.din[c_sr_ie];
                end
                if (w_mtc0 && (bus.addr == c_reg_epc)) begin
                    r_epc <= align4(bus.din);
                end
                if (bus.eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux, combinational on addr
    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            c_reg_sr:      bus.dout = w_sr;
            c_reg_cause:   bus.dout = w_cause;
            c_reg_epc:     bus.dout = r_epc;
            c_reg_prid:    bus.dout = PRID_VAL;
`ifdef CP0_TIMER_EN
            c_reg_count:   bus.dout = w_count;
            c_reg_compare: bus.dout = w_compare;
`endif
            default:       bus.dout = 32'd0;
        endcase
    end

    // EPC bypass lets an mtc0 EPC be followed directly by eret
    assign bus.epc_out    = (bus.we && (bus.addr == c_reg_epc)) ? align4(bus.din) : r_epc;
    assign bus.handler_pc = HANDLER_ADDR;
    assign bus.req        = w_req;
endmodule
`default_nettype wire
